// File: rtl/com_feeder_pkg.sv
// Shared definitions for the centroid pixel feeder.
//   state_t  : feeder FSM states
//   X_W/Y_W  : coordinate widths seen by center_of_mass
//   CNT_W    : width of the per-frame selected-pixel count
//   CNT_MAX  : saturation value of that count
package com_feeder_pkg;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int CNT_W = 20;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    TAB   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/com_pixel_feeder_raster_counter.sv
// Raster x/y position tracker for the pixel feeder.
// Ports:
//   clk_in, rst_in : clock, async active-high reset
//   i_advance      : a pixel is consumed this cycle; step to the next position
//   i_restart      : the current pixel is forced to (0,0)
//   o_x, o_y       : position of the pixel presented this cycle (0 when restarting)
//   o_last         : that pixel is the final pixel of the frame
//   o_home         : stored position is (0,0), independent of i_restart
module raster_counter
  import com_feeder_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           i_advance,
  input  logic           i_restart,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last,
  output logic           o_home
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_x_end;

  assign o_x     = i_restart ? '0 : r_x;
  assign o_y     = i_restart ? '0 : r_y;
  assign w_x_end = (o_x == X_LAST);
  assign o_last  = w_x_end && (o_y == Y_LAST);
  assign o_home  = (r_x == '0) && (r_y == '0);

  // The last pixel wraps both counters so the next frame starts at (0,0).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= o_last ? '0 : o_y + 1'b1;
      end else begin
        r_x <= o_x + 1'b1;
        r_y <= o_y;
      end
    end else if (i_restart) begin
      r_x <= '0;
      r_y <= '0;
    end
  end

endmodule

// File: rtl/com_pixel_feeder.sv
// Producer side of the centroid interface: converts a raster pixel stream and
// its threshold mask into (x, y, valid) coordinates, then issues an
// end-of-frame tabulate strobe after a drain gap together with the frame's
// selected-pixel count.
// Ports:
//   clk_in, rst_in          : clock, async active-high reset
//   pixel_valid_in, sof_in  : raster pixel strobe, start-of-frame qualifier
//   mask_in                 : pixel is selected
//   x_out, y_out, valid_out : selected pixel coordinates (1-cycle latency)
//   tabulate_out            : end-of-frame strobe
//   pixel_count_out         : selected pixels of last completed frame
//   count_valid_out         : strobe with tabulate_out
//   frame_abort_out         : frame restarted before completing
// Optional: COM_FEEDER_ROI_EN adds roi_x_min/roi_x_max/roi_y_min/roi_y_max,
// sampled at sof, restricting which masked pixels are emitted and counted.
//
// state | meaning
// IDLE  | waiting for a valid sof pixel
// SCAN  | accepting raster pixels of the current frame
// DRAIN | frame done, counting down the gap before tabulate
// TAB   | one cycle: publish the count and fire tabulate next cycle
module com_pixel_feeder
  import com_feeder_pkg::*;
#(
  parameter int H_ACTIVE     = 1024,
  parameter int V_ACTIVE     = 768,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             pixel_valid_in,
  input  logic             sof_in,
  input  logic             mask_in,
`ifdef COM_FEEDER_ROI_EN
  input  logic [X_W-1:0]   roi_x_min,
  input  logic [X_W-1:0]   roi_x_max,
  input  logic [Y_W-1:0]   roi_y_min,
  input  logic [Y_W-1:0]   roi_y_max,
`endif
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic             valid_out,
  output logic             tabulate_out,
  output logic [CNT_W-1:0] pixel_count_out,
  output logic             count_valid_out,
  output logic             frame_abort_out
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t             r_state, w_state_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0]   r_run_cnt;

  logic               w_accept, w_restart, w_abort, w_sel, w_in_roi;
  logic [X_W-1:0]     w_x;
  logic [Y_W-1:0]     w_y;
  logic               w_last, w_home;

  // IDLE only takes a sof pixel; any sof in SCAN restarts the raster.
  assign w_accept  = pixel_valid_in &&
                     ((r_state == SCAN) || ((r_state == IDLE) && sof_in));
  assign w_restart = w_accept && sof_in;
  assign w_abort   = w_restart && (r_state == SCAN) && !w_home;

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .i_advance (w_accept),
    .i_restart (w_restart),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_last    (w_last),
    .o_home    (w_home)
  );

`ifdef COM_FEEDER_ROI_EN
  logic [X_W-1:0] r_roi_x_min, r_roi_x_max, w_roi_x_min, w_roi_x_max;
  logic [Y_W-1:0] r_roi_y_min, r_roi_y_max, w_roi_y_min, w_roi_y_max;

  // The sof pixel itself must see the bounds presented alongside it.
  assign w_roi_x_min = w_restart ? roi_x_min : r_roi_x_min;
  assign w_roi_x_max = w_restart ? roi_x_max : r_roi_x_max;
  assign w_roi_y_min = w_restart ? roi_y_min : r_roi_y_min;
  assign w_roi_y_max = w_restart ? roi_y_max : r_roi_y_max;
  assign w_in_roi    = (w_x >= w_roi_x_min) && (w_x <= w_roi_x_max) &&
                       (w_y >= w_roi_y_min) && (w_y <= w_roi_y_max);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_roi_x_min <= '0;
      r_roi_x_max <= '0;
      r_roi_y_min <= '0;
      r_roi_y_max <= '0;
    end else if (w_restart) begin
      r_roi_x_min <= roi_x_min;
      r_roi_x_max <= roi_x_max;
      r_roi_y_min <= roi_y_min;
      r_roi_y_max <= roi_y_max;
    end
  end
`else
  assign w_in_roi = 1'b1;
`endif

  assign w_sel = w_accept && mask_in && w_in_roi;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_last ? DRAIN : SCAN;
      SCAN:    if (w_accept && w_last) w_state_nxt = DRAIN;
      // Counter sits at 1 in the final drain cycle, giving DRAIN_CYCLES cycles.
      DRAIN:   if (r_drain_cnt == DRAIN_W'(1)) w_state_nxt = TAB;
      TAB:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_drain_cnt     <= '0;
      r_run_cnt       <= '0;
      x_out           <= '0;
      y_out           <= '0;
      valid_out       <= 1'b0;
      tabulate_out    <= 1'b0;
      count_valid_out <= 1'b0;
      pixel_count_out <= '0;
      frame_abort_out <= 1'b0;
    end else begin
      valid_out       <= w_sel;
      tabulate_out    <= (r_state == TAB);
      count_valid_out <= (r_state == TAB);
      frame_abort_out <= w_abort;

      if (w_sel) begin
        x_out <= w_x;
        y_out <= w_y;
      end

      if (w_accept && w_last)
        r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
      else if (r_state == DRAIN)
        r_drain_cnt <= r_drain_cnt - 1'b1;

      if (r_state == TAB) begin
        pixel_count_out <= r_run_cnt;
        r_run_cnt       <= '0;
      end else if (w_restart) begin
        r_run_cnt <= {{(CNT_W-1){1'b0}}, w_sel};
      end else if (w_sel) begin
        r_run_cnt <= sat_inc(r_run_cnt);
      end
    end
  end

endmodule

// File: tb/tb_com_pixel_feeder.sv
module tb_com_pixel_feeder;

  localparam int H = 8;
  localparam int V = 4;
  localparam int D = 4;
  localparam int NPIX = H * V;
  localparam int CMAX = (1 << 20) - 1;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        pixel_valid_in, sof_in, mask_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out, tabulate_out, count_valid_out, frame_abort_out;
  logic [19:0] pixel_count_out;

  int tb_rx_min = 0, tb_rx_max = 2047, tb_ry_min = 0, tb_ry_max = 1023;

  com_pixel_feeder #(.H_ACTIVE(H), .V_ACTIVE(V), .DRAIN_CYCLES(D)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pixel_valid_in  (pixel_valid_in),
    .sof_in          (sof_in),
    .mask_in         (mask_in),
`ifdef COM_FEEDER_ROI_EN
    .roi_x_min       (11'(tb_rx_min)),
    .roi_x_max       (11'(tb_rx_max)),
    .roi_y_min       (10'(tb_ry_min)),
    .roi_y_max       (10'(tb_ry_max)),
`endif
    .x_out           (x_out),
    .y_out           (y_out),
    .valid_out       (valid_out),
    .tabulate_out    (tabulate_out),
    .pixel_count_out (pixel_count_out),
    .count_valid_out (count_valid_out),
    .frame_abort_out (frame_abort_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: linear pixel index, cycle timestamps for the tabulate.
  int m_mode;  // 0 waiting for sof, 1 in frame, 2 frame done
  int m_idx, m_run, m_tab_cycle;
  int m_rxmin, m_rxmax, m_rymin, m_rymax;
  int e_valid, e_x, e_y, e_tab, e_cv, e_pc, e_abort;

  // Per-frame observations.
  int vx[$];
  int vy[$];
  int n_tab, n_abort, tab_cyc, last_pix;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_run = 0; m_tab_cycle = 0;
    m_rxmin = 0; m_rxmax = 2047; m_rymin = 0; m_rymax = 1023;
    e_valid = 0; e_x = 0; e_y = 0; e_tab = 0; e_cv = 0; e_pc = 0; e_abort = 0;
  endtask

  task automatic model_step(input bit pv, input bit sof, input bit mask);
    int x, y;
    e_valid = 0; e_tab = 0; e_cv = 0; e_abort = 0;
    if (m_mode == 2) begin
      if (cyc == m_tab_cycle - 1) begin
        e_tab = 1; e_cv = 1; e_pc = m_run; m_run = 0; m_mode = 0;
      end
    end else if (pv && (m_mode == 1 || sof)) begin
      if (sof) begin
        if (m_mode == 1 && m_idx != 0) e_abort = 1;
        m_idx = 0; m_run = 0;
        m_rxmin = tb_rx_min; m_rxmax = tb_rx_max;
        m_rymin = tb_ry_min; m_rymax = tb_ry_max;
      end
      m_mode = 1;
      x = m_idx % H;
      y = m_idx / H;
      if (mask && x >= m_rxmin && x <= m_rxmax && y >= m_rymin && y <= m_rymax) begin
        e_valid = 1; e_x = x; e_y = y;
        m_run = (m_run + 1 > CMAX) ? CMAX : m_run + 1;
      end
      if (m_idx == NPIX - 1) begin
        m_mode = 2; m_idx = 0; m_tab_cycle = cyc + D + 2;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic cycle(input bit pv, input bit sof, input bit mask);
    pixel_valid_in = pv; sof_in = sof; mask_in = mask;
    model_step(pv, sof, mask);
    @(posedge clk_in); #1;
    cyc++;
    chk("valid_out", 32'(valid_out), 32'(e_valid));
    chk("x_out", 32'(x_out), 32'(e_x));
    chk("y_out", 32'(y_out), 32'(e_y));
    chk("tabulate_out", 32'(tabulate_out), 32'(e_tab));
    chk("count_valid_out", 32'(count_valid_out), 32'(e_cv));
    chk("pixel_count_out", 32'(pixel_count_out), 32'(e_pc));
    chk("frame_abort_out", 32'(frame_abort_out), 32'(e_abort));
    if (valid_out) begin vx.push_back(int'(x_out)); vy.push_back(int'(y_out)); end
    if (tabulate_out) begin n_tab++; tab_cyc = cyc; end
    if (frame_abort_out) n_abort++;
  endtask

  function automatic bit mask_of(input int mm, input int i);
    case (mm)
      0:       return (i == 1*H + 3) || (i == 3*H + 7);
      1:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // One frame (optionally preceded by an aborted partial frame), then the
  // drain window filled with sof pixels that must be ignored.
  task automatic drive_frame(input bit stall, input int abort_idx, input int mm);
    vx.delete(); vy.delete();
    n_tab = 0; n_abort = 0; tab_cyc = -1; last_pix = -1;
    for (int i = 0; i < abort_idx; i++) cycle(1'b1, i == 0, mask_of(mm, i));
    for (int i = 0; i < NPIX; i++) begin
      if (stall) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, i == 0, mask_of(mm, i));
    end
    last_pix = cyc - 1;
    for (int i = 0; i < D + 1; i++) cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit stall;
    int abort_idx;
    int mmode;
    int exp_valids;
    int exp_count;
    int exp_tabs;
    int exp_aborts;
  } scen_t;

  scen_t sc[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sc[0] = '{stall: 0, abort_idx: 0,  mmode: 0, exp_valids: 2,  exp_count: 2,  exp_tabs: 1, exp_aborts: 0};
    sc[1] = '{stall: 1, abort_idx: 0,  mmode: 0, exp_valids: 2,  exp_count: 2,  exp_tabs: 1, exp_aborts: 0};
    sc[2] = '{stall: 0, abort_idx: 0,  mmode: 1, exp_valids: 0,  exp_count: 0,  exp_tabs: 1, exp_aborts: 0};
    sc[3] = '{stall: 0, abort_idx: 21, mmode: 2, exp_valids: 53, exp_count: 32, exp_tabs: 1, exp_aborts: 1};
    sc[4] = '{stall: 0, abort_idx: 0,  mmode: 2, exp_valids: 32, exp_count: 32, exp_tabs: 1, exp_aborts: 0};

    rst_in = 1'b1; pixel_valid_in = 1'b0; sof_in = 1'b0; mask_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset valid_out", 32'(valid_out), 0);
    chk("reset x_out", 32'(x_out), 0);
    chk("reset y_out", 32'(y_out), 0);
    chk("reset tabulate_out", 32'(tabulate_out), 0);
    chk("reset pixel_count_out", 32'(pixel_count_out), 0);
    chk("reset count_valid_out", 32'(count_valid_out), 0);
    chk("reset frame_abort_out", 32'(frame_abort_out), 0);
    rst_in = 1'b0;

    for (int s = 0; s < 5; s++) begin
      drive_frame(sc[s].stall, sc[s].abort_idx, sc[s].mmode);
      chk($sformatf("s%0d valid count", s), 32'(vx.size()), 32'(sc[s].exp_valids));
      chk($sformatf("s%0d tab count", s), 32'(n_tab), 32'(sc[s].exp_tabs));
      chk($sformatf("s%0d abort count", s), 32'(n_abort), 32'(sc[s].exp_aborts));
      chk($sformatf("s%0d pixel count", s), 32'(pixel_count_out), 32'(sc[s].exp_count));
      chk($sformatf("s%0d tab gap", s), 32'(tab_cyc - last_pix), 32'(D + 2));
      if (sc[s].mmode == 0 && vx.size() == 2) begin
        chk($sformatf("s%0d first xy", s), 32'(vx[0] * 100 + vy[0]), 32'(301));
        chk($sformatf("s%0d second xy", s), 32'(vx[1] * 100 + vy[1]), 32'(703));
      end
    end

    // Asynchronous reset in the middle of a scan, between clock edges.
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 10; i++) cycle(1'b1, 1'b0, 1'b1);
    #3;
    rst_in = 1'b1;
    #1;
    chk("async valid_out", 32'(valid_out), 0);
    chk("async x_out", 32'(x_out), 0);
    chk("async y_out", 32'(y_out), 0);
    chk("async tabulate_out", 32'(tabulate_out), 0);
    chk("async pixel_count_out", 32'(pixel_count_out), 0);
    chk("async count_valid_out", 32'(count_valid_out), 0);
    chk("async frame_abort_out", 32'(frame_abort_out), 0);
    pixel_valid_in = 1'b0; sof_in = 1'b0; mask_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset();
    drive_frame(1'b0, 0, 0);
    chk("post-reset valid count", 32'(vx.size()), 2);
    chk("post-reset tab count", 32'(n_tab), 1);
    chk("post-reset pixel count", 32'(pixel_count_out), 2);

`ifdef COM_FEEDER_ROI_EN
    tb_rx_min = 2; tb_rx_max = 4; tb_ry_min = 1; tb_ry_max = 1;
    drive_frame(1'b0, 0, 2);
    chk("roi valid count", 32'(vx.size()), 3);
    chk("roi pixel count", 32'(pixel_count_out), 3);
    if (vx.size() == 3) begin
      chk("roi xy0", 32'(vx[0] * 100 + vy[0]), 201);
      chk("roi xy1", 32'(vx[1] * 100 + vy[1]), 301);
      chk("roi xy2", 32'(vx[2] * 100 + vy[2]), 401);
    end
    tb_rx_min = 5; tb_rx_max = 1; tb_ry_min = 0; tb_ry_max = 3;
    drive_frame(1'b0, 0, 2);
    chk("roi empty valid count", 32'(vx.size()), 0);
    chk("roi empty pixel count", 32'(pixel_count_out), 0);
    tb_rx_min = 0; tb_rx_max = 2047; tb_ry_min = 0; tb_ry_max = 1023;
`endif

    // Randomized traffic: stalls, stray sofs (aborts), random masks.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 50) == 0, $urandom % 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
